fwft_frame_reader: RTL and testbench

Single-clock consumer for the read side of the FWFT FIFO. It pops bytes with the empty/rd_enable/rd_data handshake and parses them as length-prefixed frames. Payload bytes are forwarded on a valid/ready byte stream, and per-frame status and counters are reported. It is the reading end of the data producer → async FIFO → processor path, clocked by the FIFO's read clock.

---
 rtl/fwft_frame_reader.sv | 164 ++++++++++++++++
 tb/tb_fwft_frame_reader.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwft_frame_reader.sv
// Length-prefixed frame parser on the read side of an FWFT FIFO.
// Define FRAME_CHECKSUM_EN to add the trailing checksum byte and CHK state.
module fwft_frame_reader #(
  parameter int unsigned MAX_LEN = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        empty,
  input  logic [7:0]  rd_data,
  output logic        rd_enable,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        frame_done,
  output logic        frame_err,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {
    HDR,
    PAYLOAD
`ifdef FRAME_CHECKSUM_EN
    , CHK
`endif
  } state_e;

  localparam logic [7:0] MAX_L = 8'(MAX_LEN);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        avail;
  logic        hdr_ok;
  logic        rd_en;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  chk_sum;
`endif

  assign avail  = !empty && !reset;
  assign hdr_ok = (rd_data != 8'd0) && (rd_data <= MAX_L);
`ifdef FRAME_CHECKSUM_EN
  assign chk_sum = sum_q + rd_data;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    rd_en       = 1'b0;
`ifdef FRAME_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    unique case (state_q)
      HDR: begin
        rd_en = avail;
        if (rd_en) begin
          if (hdr_ok) begin
            cnt_d   = rd_data;
            state_d = PAYLOAD;
`ifdef FRAME_CHECKSUM_EN
            sum_d   = rd_data;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      PAYLOAD: begin
        // Only pop when the output register is free or draining
        rd_en = avail && (!out_valid_q || out_ready);
        if (rd_en) begin
          out_data_d  = rd_data;
          out_valid_d = 1'b1;
          out_last_d  = (cnt_q == 8'd1);
          cnt_d       = cnt_q - 8'd1;
`ifdef FRAME_CHECKSUM_EN
          sum_d       = chk_sum;
          if (cnt_q == 8'd1) state_d = CHK;
`else
          if (cnt_q == 8'd1) begin
            state_d = HDR;
            done_d  = 1'b1;
          end
`endif
        end
      end
`ifdef FRAME_CHECKSUM_EN
      CHK: begin
        rd_en = avail;
        if (rd_en) begin
          if (chk_sum == 8'h00) done_d = 1'b1;
          else                  err_d  = 1'b1;
          state_d = HDR;
        end
      end
`endif
      default: state_d = HDR;
    endcase

    if (done_d) frame_cnt_d = frame_cnt_q + 16'd1;
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HDR;
      cnt_q       <= 8'd0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= 16'd0;
      err_cnt_q   <= 8'd0;
`ifdef FRAME_CHECKSUM_EN
      sum_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
`ifdef FRAME_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign rd_enable  = rd_en;
  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_fwft_frame_reader.sv
// Scoreboard bench for fwft_frame_reader with an FWFT FIFO model.
// Works with FRAME_CHECKSUM_EN defined or undefined.
module tb_fwft_frame_reader;

`ifdef FRAME_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        empty = 1'b1;
  logic [7:0]  rd_data = 8'h00;
  logic        out_ready = 1'b1;
  logic        rd_enable;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        frame_done;
  logic        frame_err;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;

  fwft_frame_reader #(.MAX_LEN(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .empty      (empty),
    .rd_data    (rd_data),
    .rd_enable  (rd_enable),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0] fifo_q[$];
  logic [8:0] exp_b[$];
  bit         exp_ev[$];
  int         acc_cyc[$];
  int         cyc = 0;
  int         pop_cyc = -10;
  bit         pop_now = 1'b0;
  bit         gap = 1'b0;
  bit         toggle = 1'b0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic put(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic eb(input logic [7:0] d, input logic l);
    exp_b.push_back({l, d});
  endtask

  // FIFO model: pops on the edge after a sampled rd_enable
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (pop_now && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pop_cyc = cyc;
    end
    #2;
    gap     = toggle ? !gap : 1'b0;
    empty   = gap || (fifo_q.size() == 0);
    rd_data = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
  end

  logic       pv_valid = 1'b0;
  logic       pv_ready = 1'b0;
  logic       pv_last = 1'b0;
  logic [7:0] pv_data = 8'h00;
  bit         pv_reset = 1'b1;

  always @(negedge clk) begin
    logic [8:0] e;
    bit ev;
    pop_now = rd_enable && !empty;
    if (rd_enable) chk("rd_en_while_empty", empty, 0);
    if (reset) chk("rd_en_in_reset", rd_enable, 0);
    if (!reset && !pv_reset && pv_valid && !pv_ready) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, pv_data);
      chk("hold_last", out_last, pv_last);
    end
    if (!reset && out_valid && out_ready) begin
      if (exp_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got %0h expected none", out_data);
      end else begin
        e = exp_b.pop_front();
        chk("out_data", out_data, e[7:0]);
        chk("out_last", out_last, e[8]);
        acc_cyc.push_back(cyc);
      end
    end
    if (!reset && (frame_done || frame_err)) begin
      chk("done_err_excl", frame_done & frame_err, 0);
      if (exp_ev.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_status: got done=%0b err=%0b expected none",
                 frame_done, frame_err);
      end else begin
        ev = exp_ev.pop_front();
        chk("status_kind", frame_done, ev);
        chk("status_timing", cyc, pop_cyc);
      end
    end
    pv_valid = out_valid;
    pv_ready = out_ready;
    pv_last  = out_last;
    pv_data  = out_data;
    pv_reset = reset;
  end

  task automatic wait_idle(input string nm, input int lim);
    int n;
    n = 0;
    while (!(fifo_q.size() == 0 && exp_b.size() == 0 &&
             exp_ev.size() == 0) && n < lim) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (n >= lim) begin
      errors++;
      $display("FAIL %s_idle: got fifo=%0d bytes=%0d events=%0d expected 0",
               nm, fifo_q.size(), exp_b.size(), exp_ev.size());
      fifo_q.delete();
      exp_b.delete();
      exp_ev.delete();
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_fcnt", frame_cnt, 0);
    chk("rst_ecnt", err_cnt, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // good frame, back-to-back payload
    acc_cyc.delete();
    put(8'h03); put(8'hA1); put(8'hB2); put(8'hC3);
    if (CK) put(8'hE7);
    eb(8'hA1, 0); eb(8'hB2, 0); eb(8'hC3, 1);
    exp_ev.push_back(1'b1);
    wait_idle("t1", 100);
    chk("t1_nbytes", acc_cyc.size(), 3);
    if (acc_cyc.size() == 3)
      chk("t1_back_to_back", acc_cyc[2] - acc_cyc[0], 2);
    chk("t1_fcnt", frame_cnt, 1);
    chk("t1_ecnt", err_cnt, 0);

    // bad checksum (no checksum byte without the macro)
    put(8'h03); put(8'hA1); put(8'hB2); put(8'hC3);
    if (CK) put(8'h00);
    eb(8'hA1, 0); eb(8'hB2, 0); eb(8'hC3, 1);
    exp_ev.push_back(!CK);
    wait_idle("t2", 100);
    chk("t2_fcnt", frame_cnt, CK ? 1 : 2);
    chk("t2_ecnt", err_cnt, CK ? 1 : 0);

    // illegal headers 0x00 and 0x11, then a good frame
    put(8'h00); put(8'h11);
    put(8'h02); put(8'h5A); put(8'h6B);
    if (CK) put(8'h39);
    exp_ev.push_back(1'b0); exp_ev.push_back(1'b0);
    eb(8'h5A, 0); eb(8'h6B, 1);
    exp_ev.push_back(1'b1);
    wait_idle("t3", 100);
    chk("t3_fcnt", frame_cnt, CK ? 2 : 3);
    chk("t3_ecnt", err_cnt, CK ? 3 : 2);

    // backpressure for 5 cycles mid-payload
    put(8'h06); put(8'h10); put(8'h20); put(8'h30);
    put(8'h40); put(8'h50); put(8'h60);
    if (CK) put(8'hAA);
    eb(8'h10, 0); eb(8'h20, 0); eb(8'h30, 0);
    eb(8'h40, 0); eb(8'h50, 0); eb(8'h60, 1);
    exp_ev.push_back(1'b1);
    n = 0;
    while (!(out_valid && out_data == 8'h30) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t4_reach_stall", n < 50, 1);
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("t4_rd_en_stall", rd_enable, 0);
      chk("t4_stall_valid", out_valid, 1);
      chk("t4_stall_data", out_data, 8'h30);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle("t4", 100);
    chk("t4_fcnt", frame_cnt, CK ? 3 : 4);

    // empty toggling every cycle
    toggle = 1'b1;
    put(8'h04); put(8'h01); put(8'h02); put(8'h03); put(8'h04);
    if (CK) put(8'hF2);
    eb(8'h01, 0); eb(8'h02, 0); eb(8'h03, 0); eb(8'h04, 1);
    exp_ev.push_back(1'b1);
    wait_idle("t5", 100);
    toggle = 1'b0;
    chk("t5_fcnt", frame_cnt, CK ? 4 : 5);

    // maximum legal length
    put(8'h10);
    for (int i = 0; i < 16; i++) begin
      put(8'(i));
      eb(8'(i), i == 15);
    end
    if (CK) put(8'h78);
    exp_ev.push_back(1'b1);
    wait_idle("t6", 100);
    chk("t6_fcnt", frame_cnt, CK ? 5 : 6);
    chk("t6_ecnt", err_cnt, CK ? 3 : 2);

    // reset mid-frame with a pending output byte
    put(8'h03); put(8'h11); put(8'h22); put(8'h33);
    if (CK) put(8'h97);
    eb(8'h11, 0); eb(8'h22, 0);
    n = 0;
    while (exp_b.size() != 1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t7_reach_reset", n < 50, 1);
    chk("t7_pending", out_valid, 1);
    out_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t7_valid", out_valid, 0);
    chk("t7_last", out_last, 0);
    chk("t7_fcnt0", frame_cnt, 0);
    chk("t7_ecnt0", err_cnt, 0);
    exp_b.delete();
    reset = 1'b0;
    out_ready = 1'b1;
    exp_ev.push_back(1'b0);
    if (CK) exp_ev.push_back(1'b0);
    wait_idle("t7", 100);
    chk("t7_ecnt", err_cnt, CK ? 2 : 1);
    chk("t7_fcnt", frame_cnt, 0);

    // error counter saturation
    for (int i = 0; i < 260; i++) begin
      put(8'h00);
      exp_ev.push_back(1'b0);
    end
    put(8'h01); put(8'h7E);
    if (CK) put(8'h81);
    eb(8'h7E, 1);
    exp_ev.push_back(1'b1);
    wait_idle("t8", 1000);
    chk("t8_ecnt_sat", err_cnt, 8'hFF);
    chk("t8_fcnt", frame_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
